// File: rtl/pdm_capture.sv
// PDM microphone capture: bit-clock generation, box-car decimation over DECIM bits, sample RAM writer.
// Define PDM_CAPTURE_BITREV_EN to write samples in bit-reversed address order (in-place FFT input).
module pdm_capture #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 10,
  parameter int DECIM    = 974,
  parameter int HALF_DIV = 1,
  parameter bit LR_SEL   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              do_get_audio,
  output logic              did_get_audio,
  output logic              busy,
  output logic              write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] data_out,
  output logic              micClk,
  output logic              micLRSel,
  input  logic              micData
);

  localparam int ACC_W = $clog2(DECIM + 1);
  localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [ACC_W-1:0]  DECIM_C  = ACC_W'(DECIM);
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic              r_mic_clk;
  logic              w_mic_tick;
  logic              r_sync1, r_sync2;
  logic [ACC_W-1:0]  r_acc, r_bit_cnt;
  logic [ACC_W-1:0]  w_acc_sum, w_bit_sum;
  logic              w_win_done;
  logic [ADDR_W-1:0] r_index, w_addr;
  logic [DATA_W-1:0] w_scaled;

  logic              r_busy, r_we, r_did;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_busy_nxt, w_we_nxt, w_did_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  // Free-running bit clock; a tick marks the cycle before micClk falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_mic_clk <= ~r_mic_clk;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_mic_tick = (r_div_cnt == DIV_LAST) && r_mic_clk;

  always_ff @(posedge clk) begin
    r_sync1 <= micData;
    r_sync2 <= r_sync1;
  end

  assign w_acc_sum  = r_acc + ACC_W'(r_sync2);
  assign w_bit_sum  = r_bit_cnt + ACC_W'(1);
  assign w_win_done = w_mic_tick && (w_bit_sum == DECIM_C);

  generate
    if (ACC_W >= DATA_W) begin : g_scale_trunc
      assign w_scaled = w_acc_sum[ACC_W-1 -: DATA_W];
    end else begin : g_scale_shift
      assign w_scaled = {w_acc_sum, {(DATA_W - ACC_W){1'b0}}};
    end
  endgenerate

`ifdef PDM_CAPTURE_BITREV_EN
  generate
    for (genvar i = 0; i < ADDR_W; i++) begin : g_bitrev
      assign w_addr[i] = r_index[ADDR_W-1-i];
    end
  endgenerate
`else
  assign w_addr = r_index;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (do_get_audio) w_state_nxt = S_ACCUM;
      S_ACCUM: if (w_win_done)   w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = (r_index == IDX_LAST) ? S_DONE : S_ACCUM;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_we_nxt   = (w_state_nxt == S_WRITE);
    w_did_nxt  = (w_state_nxt == S_DONE);
    w_addr_nxt = r_addr;
    w_data_nxt = r_data;
    if (w_we_nxt) begin
      w_addr_nxt = w_addr;
      w_data_nxt = w_scaled;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_index   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_acc     <= '0;
          r_bit_cnt <= '0;
          r_index   <= '0;
        end
        S_ACCUM: begin
          if (w_mic_tick) begin
            r_acc     <= w_acc_sum;
            r_bit_cnt <= w_bit_sum;
          end
        end
        S_WRITE: begin
          // A tick landing in the write cycle opens the next window.
          r_acc     <= w_mic_tick ? ACC_W'(r_sync2) : '0;
          r_bit_cnt <= w_mic_tick ? ACC_W'(1) : '0;
          r_index   <= r_index + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_we   <= 1'b0;
      r_did  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_we   <= w_we_nxt;
      r_did  <= w_did_nxt;
      r_addr <= w_addr_nxt;
      r_data <= w_data_nxt;
    end
  end

  assign busy          = r_busy;
  assign write_enable  = r_we;
  assign did_get_audio = r_did;
  assign mem_addr      = r_addr;
  assign data_out      = r_data;
  assign micClk        = r_mic_clk;
  assign micLRSel      = LR_SEL;

endmodule

// File: tb/tb_pdm_capture.sv
// Bench for pdm_capture: random and patterned PDM streams checked against a window-sum reference model.
module tb_pdm_capture;
  localparam int  ADDR_W   = 3;
  localparam int  DATA_W   = 3;
  localparam int  DECIM    = 4;
  localparam int  HALF_DIV = 1;
  localparam bit  LR_SEL   = 1'b0;
  localparam int  N        = 8;
  localparam int  HIST     = 16384;

  logic              clk = 1'b0;
  logic              rst_n, do_get_audio, micData;
  logic              did_get_audio, busy, write_enable, micClk, micLRSel;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] data_out;

  pdm_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DECIM(DECIM), .HALF_DIV(HALF_DIV), .LR_SEL(LR_SEL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .do_get_audio(do_get_audio), .did_get_audio(did_get_audio),
    .busy(busy), .write_enable(write_enable), .mem_addr(mem_addr), .data_out(data_out),
    .micClk(micClk), .micLRSel(micLRSel), .micData(micData)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // 0: all zeros, 1: all ones, 2: alternate per mic tick, 3: random per cycle
  int mode = 0;
  int drv_cnt = 0;
  initial begin
    micData = 1'b0;
    forever begin
      @(posedge clk); #1;
      drv_cnt++;
      case (mode)
        0:       micData = 1'b0;
        1:       micData = 1'b1;
        2:       micData = drv_cnt[1];
        default: micData = 1'($urandom % 2);
      endcase
    end
  end

  // Reference model: every cycle with micClk high is a tick, the bit it consumes is the pin
  // value two cycles earlier, and write k carries the sum of consumed bits 4k..4k+3.
  int   seq[N];
  bit   hist[HIST];
  int   cyc = 0;
  bit   mon_on = 0;
  bit   active = 0;
  int   bits[$];
  int   nwr = 0;
  int   n_did = 0;
  logic [31:0] exp_d;
  logic prev_busy = 1'b0, prev_we = 1'b0, prev_did = 1'b0;

  always @(negedge clk) begin
    cyc++;
    hist[cyc % HIST] = micData;
    if (mon_on) begin
      if (!rst_n) begin
        active = 0;
      end else begin
        if (busy && !prev_busy) begin
          active = 1;
          bits.delete();
          nwr = 0;
        end
        if (prev_did) chk("busy_after_did", busy, 0);
        if (!active) chk("we_idle", write_enable, 0);
        else if (write_enable) begin
          exp_d = 0;
          if (bits.size() >= 4*nwr + 4) for (int i = 0; i < 4; i++) exp_d += bits[4*nwr + i];
          else exp_d = 32'hFFFF_FFFF;
          chk("wr_bits", bits.size(), 4*nwr + 4);
          chk("wr_data", data_out, exp_d);
          chk("wr_addr", mem_addr, seq[nwr % N]);
          if (mode == 0) chk("wr_zero", data_out, 0);
          if (mode == 1) chk("wr_ones", data_out, 4);
          if (mode == 2) chk("wr_alt", data_out, 2);
          nwr++;
        end
        if (did_get_audio) begin
          n_did++;
          chk("did_nwr", nwr, N);
          chk("did_bits", bits.size(), N*DECIM);
          chk("did_after_we", prev_we, 1);
          active = 0;
        end
        if (active && micClk) bits.push_back(hist[(cyc - 2) % HIST]);
      end
    end
    prev_busy = busy;
    prev_we   = write_enable;
    prev_did  = did_get_audio;
  end

  task automatic wait_did(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (did_get_audio === 1'b1) seen = 1;
    end
    chk("did_seen", seen, 1);
  endtask

  task automatic start_pulse(input int m);
    mode = m;
    repeat (4) @(posedge clk);
    #1 do_get_audio = 1'b1;
    @(posedge clk);
    #1 do_get_audio = 1'b0;
  endtask

  task automatic run_capture(input int m);
    start_pulse(m);
    wait_did(400);
    @(negedge clk);
    chk("did_pulse", did_get_audio, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr;
    int d0;
`ifdef PDM_CAPTURE_BITREV_EN
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    seq = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    rst_n = 1'b0;
    do_get_audio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_did", did_get_audio, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", data_out, 0);
    chk("rst_micclk", micClk, 0);
    chk("rst_lrsel", micLRSel, LR_SEL);
    rst_n = 1'b1;
    mon_on = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("micclk_run", micClk, i % 2);
    end

    run_capture(1);
    run_capture(0);
    run_capture(2);
    for (int i = 0; i < 3; i++) run_capture(3);

    // Abort after the third write, then restart from index 0.
    start_pulse(3);
    wr = 0;
    for (int i = 0; i < 300 && wr < 3; i++) begin
      @(negedge clk);
      if (write_enable === 1'b1) wr++;
    end
    chk("abort_reach3", wr, 3);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_we", write_enable, 0);
    chk("abort_busy", busy, 0);
    d0 = n_did;
    repeat (100) @(negedge clk);
    chk("abort_no_did", n_did, d0);
    run_capture(3);

    // Start held high: back-to-back captures with a single idle cycle between.
    mode = 3;
    @(posedge clk); #1 do_get_audio = 1'b1;
    wait_did(400);
    chk("b2b_busy_did", busy, 1);
    @(negedge clk);
    chk("b2b_busy_gap", busy, 0);
    @(negedge clk);
    chk("b2b_busy_restart", busy, 1);
    do_get_audio = 1'b0;
    wait_did(400);
    repeat (10) @(negedge clk);
    chk("b2b_idle", busy, 0);
    chk("did_total", n_did, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
